// File: rtl/uart_rx_ctrl.sv
// UART receiver: input synchronizer, mid-bit sampling timer, frame FSM,
// single-entry output holding register and sticky error flags.
module uart_rx_ctrl #(
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [15:0]          period,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   input  logic                 err_clr,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun_err,
   output logic                 busy
);

   localparam int unsigned CNT_W = 16;
   localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   dly_q;
   logic                   rxd_s;
   logic                   fall;

   logic [CNT_W-1:0]       p_eff;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   tmr_en;
   logic                   tick;

   logic [2:0]             state_q, state_d;
   logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   par_en_q, par_en_d;
   logic                   par_odd_q, par_odd_d;
   logic                   par_bad_q, par_bad_d;
   logic                   done_good, done_par, done_frame;

   logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   frame_err_q, frame_err_d;
   logic                   parity_err_q, parity_err_d;
   logic                   overrun_err_q, overrun_err_d;
   logic                   busy_q;

   // Metastability synchronizer plus one delay flop for edge detection
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_q <= '1;
         dly_q  <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
         dly_q  <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rxd_s = sync_q[SYNC_STAGES-1];
   assign fall  = !rxd_s && dly_q;

   // Bit timer: preloaded to half a bit so the first tick lands mid start bit
   assign p_eff  = (period < 16'd4) ? 16'd4 : period;
   assign tmr_en = (state_q != S_IDLE);
   assign tick   = tmr_en && (cnt_q == (p_eff - 16'd1));

   always_comb begin
      cnt_d = cnt_q;
      if (!tmr_en)      cnt_d = p_eff >> 1;
      else if (tick)    cnt_d = '0;
      else              cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   // Frame FSM next-state and datapath
   always_comb begin
      state_d    = state_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      par_en_d   = par_en_q;
      par_odd_d  = par_odd_q;
      par_bad_d  = par_bad_q;
      done_good  = 1'b0;
      done_par   = 1'b0;
      done_frame = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (fall) begin
               state_d   = S_START;
               par_en_d  = parity_en;
               par_odd_d = parity_odd;
               par_bad_d = 1'b0;
            end
         end
         S_START: begin
            if (tick) begin
               if (!rxd_s) begin
                  state_d   = S_DATA;
                  bit_idx_d = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               shift_d[bit_idx_q] = rxd_s;
               if (bit_idx_q == IDX_W'(DATA_BITS - 1))
                  state_d = par_en_q ? S_PARITY : S_STOP;
               else
                  bit_idx_d = bit_idx_q + IDX_W'(1);
            end
         end
         S_PARITY: begin
            if (tick) begin
               if (rxd_s != ((^shift_q) ^ par_odd_q)) par_bad_d = 1'b1;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (tick) begin
               state_d = S_IDLE;
               if (!rxd_s)         done_frame = 1'b1;
               else if (par_bad_q) done_par   = 1'b1;
               else                done_good  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output holding register and sticky error flags
   always_comb begin
      rx_data_d     = rx_data_q;
      rx_valid_d    = rx_valid_q;
      frame_err_d   = (frame_err_q   && !err_clr) || done_frame;
      parity_err_d  = (parity_err_q  && !err_clr) || done_par;
      overrun_err_d = overrun_err_q && !err_clr;
      if (done_good) begin
         if (!rx_valid_q || rx_ready) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
         end else begin
            overrun_err_d = 1'b1;
         end
      end else if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= S_IDLE;
         bit_idx_q     <= '0;
         shift_q       <= '0;
         par_en_q      <= 1'b0;
         par_odd_q     <= 1'b0;
         par_bad_q     <= 1'b0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         frame_err_q   <= 1'b0;
         parity_err_q  <= 1'b0;
         overrun_err_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         bit_idx_q     <= bit_idx_d;
         shift_q       <= shift_d;
         par_en_q      <= par_en_d;
         par_odd_q     <= par_odd_d;
         par_bad_q     <= par_bad_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         frame_err_q   <= frame_err_d;
         parity_err_q  <= parity_err_d;
         overrun_err_q <= overrun_err_d;
         busy_q        <= (state_d != S_IDLE);
      end
   end

   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign frame_err   = frame_err_q;
   assign parity_err  = parity_err_q;
   assign overrun_err = overrun_err_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl with a queue of expected words.
module tb_uart_rx_ctrl;

   localparam int unsigned P = 16;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [15:0] period = 16'(P);
   logic        parity_en = 1'b0;
   logic        parity_odd = 1'b0;
   logic        rxd = 1'b1;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready = 1'b0;
   logic        err_clr = 1'b0;
   logic        frame_err, parity_err, overrun_err, busy;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  exp_q[$];

   always #5 clk = ~clk;

   uart_rx_ctrl #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
      .clk(clk), .rstn(rstn), .period(period), .parity_en(parity_en),
      .parity_odd(parity_odd), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .err_clr(err_clr), .frame_err(frame_err),
      .parity_err(parity_err), .overrun_err(overrun_err), .busy(busy)
   );

   // Serialize one frame on rxd; optionally queue the word as expected output
   task automatic send_frame(input logic [7:0] data, input bit with_par,
                             input bit par_bit, input bit push);
      if (push) exp_q.push_back(data);
      @(negedge clk);
      rxd = 1'b0;
      repeat (P) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = data[i];
         repeat (P) @(negedge clk);
      end
      if (with_par) begin
         rxd = par_bit;
         repeat (P) @(negedge clk);
      end
      rxd = 1'b1;
      repeat (P) @(negedge clk);
   endtask

   // Wait for a word, compare to the scoreboard head, then consume it
   task automatic check_word(input string name);
      logic [7:0] exp;
      int t = 0;
      while (!rx_valid && t < 8 * P) begin
         @(negedge clk);
         t++;
      end
      n_checks++;
      if (!rx_valid) begin
         n_errors++;
         $display("FAIL %s: rx_valid timeout, got %b want 1", name, rx_valid);
      end else if (exp_q.size() == 0) begin
         n_errors++;
         $display("FAIL %s: unexpected word %h, scoreboard empty", name, rx_data);
      end else begin
         exp = exp_q.pop_front();
         if (rx_data !== exp) begin
            n_errors++;
            $display("FAIL %s: rx_data got %h want %h", name, rx_data, exp);
         end
      end
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      n_checks++;
      if (rx_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL %s_consume: rx_valid got %b want 0", name, rx_valid);
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      #1;
      n_checks++;
      if ({rx_valid, frame_err, parity_err, overrun_err, busy} !== 5'b0 || rx_data !== 8'h00) begin
         n_errors++;
         $display("FAIL reset: flags %b data %h want 00000 00",
                  {rx_valid, frame_err, parity_err, overrun_err, busy}, rx_data);
      end
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_basic();
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if ({frame_err, parity_err, overrun_err} !== 3'b000) begin
         n_errors++;
         $display("FAIL basic_flags: got %b want 000", {frame_err, parity_err, overrun_err});
      end
      check_word("basic_a5");
   endtask

   task automatic test_glitch();
      bit seen_busy = 1'b0;
      @(negedge clk);
      rxd = 1'b0;
      repeat (3) @(negedge clk);
      rxd = 1'b1;
      for (int i = 0; i < 4 * P; i++) begin
         if (busy) seen_busy = 1'b1;
         @(negedge clk);
      end
      n_checks++;
      if (seen_busy !== 1'b1) begin
         n_errors++;
         $display("FAIL glitch_start: busy seen %b want 1", seen_busy);
      end
      n_checks++;
      if ({busy, rx_valid, frame_err, parity_err, overrun_err} !== 5'b0) begin
         n_errors++;
         $display("FAIL glitch_reject: busy/valid/flags %b want 00000",
                  {busy, rx_valid, frame_err, parity_err, overrun_err});
      end
   endtask

   task automatic test_parity();
      logic [7:0] d;
      parity_en = 1'b1;
      parity_odd = 1'b0;
      send_frame(8'h03, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if (parity_err !== 1'b1 || rx_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL parity_bad: parity_err %b rx_valid %b want 1 0", parity_err, rx_valid);
      end
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      n_checks++;
      if (parity_err !== 1'b0) begin
         n_errors++;
         $display("FAIL parity_clr: got %b want 0", parity_err);
      end
      d = 8'h07;
      send_frame(d, 1'b1, ^d, 1'b1);
      check_word("parity_even_ok");
      parity_odd = 1'b1;
      d = 8'h5C;
      send_frame(d, 1'b1, ~(^d), 1'b1);
      check_word("parity_odd_ok");
      n_checks++;
      if (parity_err !== 1'b0) begin
         n_errors++;
         $display("FAIL parity_good_flag: got %b want 0", parity_err);
      end
      parity_en = 1'b0;
      parity_odd = 1'b0;
   endtask

   task automatic test_overrun();
      send_frame(8'h11, 1'b0, 1'b0, 1'b1);
      send_frame(8'h22, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (overrun_err !== 1'b1) begin
         n_errors++;
         $display("FAIL overrun_set: got %b want 1", overrun_err);
      end
      check_word("overrun_keep_old");
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      // Second pass: consume 0x11 on the exact completion cycle of 0x22
      send_frame(8'h11, 1'b0, 1'b0, 1'b1);
      fork
         send_frame(8'h22, 1'b0, 1'b0, 1'b1);
         begin
            logic [7:0] exp;
            @(negedge clk);
            repeat (11 + P * 9 - 1) @(negedge clk);
            exp = exp_q.pop_front();
            n_checks++;
            if (rx_valid !== 1'b1 || rx_data !== exp) begin
               n_errors++;
               $display("FAIL b2b_first: valid %b data %h want 1 %h", rx_valid, rx_data, exp);
            end
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
         end
      join
      n_checks++;
      if (overrun_err !== 1'b0) begin
         n_errors++;
         $display("FAIL b2b_no_overrun: got %b want 0", overrun_err);
      end
      check_word("b2b_second");
   endtask

   task automatic test_break();
      @(negedge clk);
      rxd = 1'b0;
      repeat (12 * P) @(negedge clk);
      n_checks++;
      if (frame_err !== 1'b1 || rx_valid !== 1'b0 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL break: frame_err %b valid %b busy %b want 1 0 0", frame_err, rx_valid, busy);
      end
      rxd = 1'b1;
      repeat (2 * P) @(negedge clk);
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
      check_word("after_break");
   endtask

   task automatic test_reset_mid();
      fork
         send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
         begin
            @(negedge clk);
            repeat (P + 4 * P + P / 2) @(negedge clk);
            #2 rstn = 1'b0;
            #1;
            n_checks++;
            if ({rx_valid, frame_err, parity_err, overrun_err, busy} !== 5'b0 || rx_data !== 8'h00) begin
               n_errors++;
               $display("FAIL reset_mid: flags %b data %h want 00000 00",
                        {rx_valid, frame_err, parity_err, overrun_err, busy}, rx_data);
            end
            @(negedge clk);
            rstn = 1'b1;
         end
      join
      n_checks++;
      if (rx_valid !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_abort: valid %b busy %b ferr %b want 0 0 0", rx_valid, busy, frame_err);
      end
      send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
      check_word("after_reset_c3");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_parity();
      test_overrun();
      test_break();
      test_reset_mid();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL scoreboard_drain: %0d words left want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame (5..8).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, rxd synchronizer depth (>=2).
REQ-003 SHALL have port clk, input, 1, single clock; all state on posedge.
REQ-004 SHALL have port rstn, input, 1; one clock, reset asynchronous and active-low.
REQ-005 SHALL have port period, input, 16, clk cycles per bit; sampled continuously; values <4 treated as 4.
REQ-006 SHALL have port parity_en, input, 1, 1 = frame carries parity bit after data.
REQ-007 SHALL have port parity_odd, input, 1, 1 = odd parity, 0 = even.
REQ-008 SHALL have port rxd, input, 1, asynchronous serial line, idle high.
REQ-009 SHALL have port rx_data, output, DATA_BITS, received word, LSB first on line.
REQ-010 SHALL have port rx_valid, output, 1, rx_data holds an unconsumed word.
REQ-011 SHALL have port rx_ready, input, 1, consumer accepts word when rx_valid && rx_ready.
REQ-012 SHALL have port err_clr, input, 1, clears all sticky error flags.
REQ-013 SHALL have ports frame_err, parity_err, overrun_err, each output, 1, sticky error flags.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-015 SHALL pass rxd through SYNC_STAGES flops (reset value 1) plus one delay flop; rxd_s = synchronized value, fall = rxd_s==0 && delayed==1.
REQ-016 SHALL contain 16-bit bit-timer cnt: en=0 -> cnt loads (P>>1), P = effective period; en=1 -> cnt+1, wrap to 0 at P-1; tick = en && cnt==P-1.
REQ-017 SHALL drive timer en=1 in START, DATA, PARITY, STOP; en=0 in IDLE, so first tick lands mid start bit (P-1-(P>>1) cycles after entry).
REQ-018 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; reset state IDLE.
REQ-019 IDLE: on fall -> START; otherwise stay.
REQ-020 START: on tick, rxd_s==0 -> DATA with bit index 0; rxd_s==1 -> IDLE (glitch rejected, no flags, no output).
REQ-021 DATA: on each tick shift rxd_s into shift register at bit index; after DATA_BITS ticks -> PARITY if parity_en else STOP.
REQ-022 PARITY: on tick compare rxd_s to expected (XOR of data, inverted if parity_odd); mismatch marks frame parity-bad; -> STOP.
REQ-023 STOP: on tick, rxd_s==0 sets frame_err, word discarded; rxd_s==1 completes frame; either case -> IDLE same edge.
REQ-024 parity_en/parity_odd SHALL be captured on IDLE->START; mid-frame changes have no effect.
REQ-025 On completion with parity-bad, parity_err SHALL set and word discarded.
REQ-026 On good completion: if rx_valid==0, or rx_valid && rx_ready that cycle, rx_data<=word and rx_valid<=1 next edge; else overrun_err sets, old rx_data kept.
REQ-027 rx_valid SHALL clear on rx_valid && rx_ready with no simultaneous good completion.
REQ-028 Error flags SHALL stay set until err_clr; set and err_clr same cycle -> flag ends set.
REQ-029 After frame_err (break/low line), new frame SHALL start only after rxd_s returns high then falls.
REQ-030 A change of period mid-frame SHALL take effect at the next cnt comparison; no recovery required.

Reset
REQ-031 rstn low SHALL immediately force: state IDLE, sync flops 1, cnt 0, shift register 0, rx_data 0, rx_valid 0, all error flags 0, busy 0.
REQ-032 rstn low mid-frame SHALL abort the frame with no output or flag; after release a new start requires a fresh falling edge.
REQ-033 rstn release SHALL be usable as asynchronously asserted, synchronously deasserted externally; the block adds no release synchronizer.

Verification
REQ-034 period=16, parity off, send 0xA5 (start 0, 1,0,1,0,0,1,0,1, stop 1) -> rx_valid=1, rx_data=0xA5, no flags; rx_ready=1 one cycle -> rx_valid=0.
REQ-035 period=16, 3-cycle low pulse on rxd -> START then IDLE, rx_valid stays 0, no flags.
REQ-036 parity_en=1, parity_odd=0, send 0x03 with parity bit 1 -> parity_err=1, rx_valid=0; err_clr=1 -> parity_err=0.
REQ-037 Send 0x11 then 0x22 with rx_ready=0 -> rx_data=0x11, overrun_err=1; repeat with rx_ready=1 on 0x22's completion cycle -> rx_data=0x22, no overrun.
REQ-038 Hold rxd=0 for 12 bit times -> frame_err=1, no word; rxd high then send 0x5A -> rx_data=0x5A.
REQ-039 rstn pulsed low during bit 4 of a frame -> all outputs 0 immediately; next full frame 0xC3 received correctly.
